// File: rtl/ysyx_22041412_burst_mem_slave.sv
// +-------------------------------------------------------------------------+
// | ysyx_22041412_burst_mem_slave                                           |
// | Memory-side responder for read/write bursts over a word-addressed RAM.  |
// | Revision: 1.0                                                           |
// +-------------------------------------------------------------------------+
`default_nettype none

module ysyx_22041412_burst_mem_slave #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 32,
  parameter int MEM_DEPTH  = 4096,
  parameter int RD_WAIT    = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  r_valid_i,
  input  logic [ADDR_WIDTH-1:0] r_addr_i,
  input  logic [7:0]            r_len_i,
  input  logic [2:0]            r_size_i,
  output logic                  r_ready_o,
  output logic [DATA_WIDTH-1:0] data_read_o,
  output logic                  r_last_i,
  input  logic                  w_valid_i,
  input  logic [ADDR_WIDTH-1:0] w_addr_i,
  input  logic [7:0]            w_len_i,
  input  logic [2:0]            w_size_i,
  input  logic [DATA_WIDTH-1:0] rw_w_data_i,
  output logic                  w_ready_o,
  output logic                  w_last_i
);

  localparam int IDX_W  = $clog2(MEM_DEPTH);
  localparam int WAIT_W = (RD_WAIT > 1) ? $clog2(RD_WAIT) : 1;
  localparam int NBYTES = DATA_WIDTH / 8;

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_WAIT = 2'd1,
    R_DATA = 2'd2
  } r_state_t;

  typedef enum logic {
    W_IDLE = 1'b0,
    W_DATA = 1'b1
  } w_state_t;

  logic [DATA_WIDTH-1:0] mem_q [MEM_DEPTH];

  r_state_t              r_state_q;
  logic [IDX_W-1:0]      r_idx_q;
  logic [7:0]            r_len_q;
  logic [7:0]            r_beat_q;
  logic [WAIT_W-1:0]     r_wait_q;

  w_state_t              w_state_q;
  logic [ADDR_WIDTH-1:0] w_addr_q;
  logic [7:0]            w_len_q;
  logic [1:0]            w_size_q;
  logic [7:0]            w_beat_q;

  logic                  rd_beat;
  logic                  rd_last;
  logic                  wr_beat;
  logic                  wr_last;
  logic [NBYTES-1:0]     wr_lanes;
  logic [NBYTES-1:0]     wr_strb;
  logic [IDX_W-1:0]      wr_idx;
  logic                  unused_bits;

  assign unused_bits = ^{r_size_i, r_addr_i[ADDR_WIDTH-1:IDX_W+3], r_addr_i[2:0]};

  // ---------------- read channel ----------------
  assign rd_beat     = (r_state_q == R_DATA) && r_valid_i;
  assign rd_last     = rd_beat && (r_beat_q == r_len_q);
  assign r_ready_o   = rd_beat;
  assign r_last_i    = rd_last;
  assign data_read_o = (r_state_q == R_DATA) ? mem_q[r_idx_q] : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state_q <= R_IDLE;
      r_idx_q   <= '0;
      r_len_q   <= '0;
      r_beat_q  <= '0;
      r_wait_q  <= '0;
    end else begin
      unique case (r_state_q)
        R_IDLE: begin
          if (r_valid_i) begin
            r_idx_q   <= r_addr_i[IDX_W+2:3];
            r_len_q   <= r_len_i;
            r_beat_q  <= '0;
            r_wait_q  <= '0;
            r_state_q <= (RD_WAIT == 0) ? R_DATA : R_WAIT;
          end
        end
        R_WAIT: begin
          if (!r_valid_i) begin
            r_state_q <= R_IDLE;
          end else if (r_wait_q == WAIT_W'(RD_WAIT - 1)) begin
            r_state_q <= R_DATA;
          end else begin
            r_wait_q <= r_wait_q + 1'b1;
          end
        end
        R_DATA: begin
          if (!r_valid_i || rd_last) begin
            r_state_q <= R_IDLE;
          end else begin
            r_idx_q  <= r_idx_q + 1'b1;
            r_beat_q <= r_beat_q + 1'b1;
          end
        end
        default: r_state_q <= R_IDLE;
      endcase
    end
  end

  // ---------------- write channel ----------------
  assign wr_beat   = (w_state_q == W_DATA) && w_valid_i;
  assign wr_last   = wr_beat && (w_beat_q == w_len_q);
  assign w_ready_o = wr_beat;
  assign w_last_i  = wr_last;
  assign wr_idx    = w_addr_q[IDX_W+2:3];

  always_comb begin
    wr_lanes = '0;
    unique case (w_size_q)
      2'd0:    wr_lanes = 8'h01;
      2'd1:    wr_lanes = 8'h03;
      2'd2:    wr_lanes = 8'h0F;
      default: wr_lanes = 8'hFF;
    endcase
  end

  // Lanes shifted past lane 7 by a misaligned address fall off the top.
  assign wr_strb = NBYTES'({{NBYTES{1'b0}}, wr_lanes} << w_addr_q[2:0]);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      w_state_q <= W_IDLE;
      w_addr_q  <= '0;
      w_len_q   <= '0;
      w_size_q  <= '0;
      w_beat_q  <= '0;
    end else begin
      unique case (w_state_q)
        W_IDLE: begin
          if (w_valid_i) begin
            w_addr_q  <= w_addr_i;
            w_len_q   <= w_len_i;
            w_size_q  <= w_size_i[2] ? 2'd3 : w_size_i[1:0];
            w_beat_q  <= '0;
            w_state_q <= W_DATA;
          end
        end
        W_DATA: begin
          if (!w_valid_i || wr_last) begin
            w_state_q <= W_IDLE;
          end else begin
            w_addr_q <= w_addr_q + (ADDR_WIDTH'(1) << w_size_q);
            w_beat_q <= w_beat_q + 1'b1;
          end
        end
        default: w_state_q <= W_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (wr_beat) begin
      for (int b = 0; b < NBYTES; b++) begin
        if (wr_strb[b]) begin
          mem_q[wr_idx][8*b +: 8] <= rw_w_data_i[8*b +: 8];
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_ysyx_22041412_burst_mem_slave.sv
// +-------------------------------------------------------------------------+
// | tb_ysyx_22041412_burst_mem_slave                                        |
// | Self-checking bench for the burst memory responder.                     |
// | Revision: 1.0                                                           |
// +-------------------------------------------------------------------------+
`default_nettype none

module tb_ysyx_22041412_burst_mem_slave;

  localparam int DW    = 64;
  localparam int AW    = 32;
  localparam int DEPTH = 4096;
  localparam int RDW   = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          r_valid_i;
  logic [AW-1:0] r_addr_i;
  logic [7:0]    r_len_i;
  logic [2:0]    r_size_i;
  logic          r_ready_o;
  logic [DW-1:0] data_read_o;
  logic          r_last_i;
  logic          w_valid_i;
  logic [AW-1:0] w_addr_i;
  logic [7:0]    w_len_i;
  logic [2:0]    w_size_i;
  logic [DW-1:0] rw_w_data_i;
  logic          w_ready_o;
  logic          w_last_i;

  always #5 clk = ~clk;

  ysyx_22041412_burst_mem_slave #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MEM_DEPTH(DEPTH), .RD_WAIT(RDW)
  ) dut (
    .clk(clk), .rst(rst),
    .r_valid_i(r_valid_i), .r_addr_i(r_addr_i), .r_len_i(r_len_i), .r_size_i(r_size_i),
    .r_ready_o(r_ready_o), .data_read_o(data_read_o), .r_last_i(r_last_i),
    .w_valid_i(w_valid_i), .w_addr_i(w_addr_i), .w_len_i(w_len_i), .w_size_i(w_size_i),
    .rw_w_data_i(rw_w_data_i), .w_ready_o(w_ready_o), .w_last_i(w_last_i)
  );

  logic [63:0] model [DEPTH];
  logic [63:0] wq [$];
  logic [63:0] rd_first;
  int total = 0;
  int bad   = 0;

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    int          size;
    logic [63:0] data;
    logic [63:0] exp;
  } vec_t;
  vec_t vecs [12];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  function automatic int widx(input logic [31:0] a);
    return int'((a >> 3) % DEPTH);
  endfunction

  // Byte-level reference: each byte of the beat lands in lane (addr%8 + b) if it exists.
  task automatic m_write(input logic [31:0] a, input int size, input logic [63:0] d);
    int nb;
    int off;
    nb  = 1 << ((size > 3) ? 3 : size);
    off = int'(a % 8);
    for (int b = 0; b < nb; b++)
      if (off + b < 8) model[widx(a)][8*(off+b) +: 8] = d[8*(off+b) +: 8];
  endtask

  task automatic do_write(input logic [31:0] a, input int len, input int size, input int abort_after = -1);
    logic [31:0] cur;
    cur = a;
    w_valid_i = 1'b1; w_addr_i = a; w_len_i = 8'(len); w_size_i = 3'(size); rw_w_data_i = '0;
    @(negedge clk); chk("w_accept_ready", 64'(w_ready_o), 64'd0);
    next_cycle();
    for (int i = 0; i <= len; i++) begin
      if (i == abort_after) break;
      rw_w_data_i = wq[i];
      @(negedge clk);
      chk("w_ready", 64'(w_ready_o), 64'd1);
      chk("w_last", 64'(w_last_i), 64'(i == len));
      m_write(cur, size, wq[i]);
      cur = cur + (32'd1 << ((size > 3) ? 3 : size));
      next_cycle();
    end
    w_valid_i = 1'b0; rw_w_data_i = '0;
    @(negedge clk); chk("w_after_ready", 64'(w_ready_o), 64'd0);
    next_cycle();
  endtask

  task automatic do_read(input logic [31:0] a, input int len, input int abort_after = -1);
    r_valid_i = 1'b1; r_addr_i = a; r_len_i = 8'(len); r_size_i = 3'($urandom_range(0, 7));
    for (int w = 0; w <= RDW; w++) begin
      @(negedge clk);
      chk("r_wait_ready", 64'(r_ready_o), 64'd0);
      chk("r_wait_data", data_read_o, 64'd0);
      next_cycle();
    end
    for (int i = 0; i <= len; i++) begin
      if (i == abort_after) break;
      @(negedge clk);
      chk("r_ready", 64'(r_ready_o), 64'd1);
      chk("r_data", data_read_o, model[(widx(a) + i) % DEPTH]);
      chk("r_last", 64'(r_last_i), 64'(i == len));
      if (i == 0) rd_first = data_read_o;
      next_cycle();
    end
    r_valid_i = 1'b0;
    @(negedge clk);
    chk("r_drop_ready", 64'(r_ready_o), 64'd0);
    chk("r_drop_last", 64'(r_last_i), 64'd0);
    next_cycle();
    @(negedge clk);
    chk("r_idle_ready", 64'(r_ready_o), 64'd0);
    chk("r_idle_data", data_read_o, 64'd0);
    next_cycle();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a;
    logic [63:0] old_v, new_v;

    vecs[0]  = '{1'b1, 32'h0000_0080, 3, 64'hDEADBEEF_01234567, 64'h0};
    vecs[1]  = '{1'b0, 32'h0000_0080, 3, 64'h0, 64'hDEADBEEF_01234567};
    vecs[2]  = '{1'b1, 32'h0000_0200, 3, 64'h0, 64'h0};
    vecs[3]  = '{1'b1, 32'h0000_0203, 0, 64'h00000000_AB000000, 64'h0};
    vecs[4]  = '{1'b1, 32'h0000_0206, 1, 64'hCDEF0000_00000000, 64'h0};
    vecs[5]  = '{1'b0, 32'h0000_0200, 3, 64'h0, 64'hCDEF0000_AB000000};
    vecs[6]  = '{1'b1, 32'h0000_0204, 2, 64'h12345678_00000000, 64'h0};
    vecs[7]  = '{1'b0, 32'h0000_0200, 3, 64'h0, 64'h12345678_AB000000};
    vecs[8]  = '{1'b1, 32'h0000_0207, 3, 64'hAABBCCDD_EEFF0011, 64'h0};
    vecs[9]  = '{1'b0, 32'h0000_0200, 3, 64'h0, 64'hAA345678_AB000000};
    vecs[10] = '{1'b1, 32'hFFFF_0300, 7, 64'h01020304_05060708, 64'h0};
    vecs[11] = '{1'b0, 32'h0000_0300, 3, 64'h0, 64'h01020304_05060708};

    rst = 1'b0;
    r_valid_i = 1'b1; r_addr_i = '0; r_len_i = '0; r_size_i = '0;
    w_valid_i = 1'b1; w_addr_i = '0; w_len_i = '0; w_size_i = '0; rw_w_data_i = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_r_ready", 64'(r_ready_o), 64'd0);
    chk("rst_r_last", 64'(r_last_i), 64'd0);
    chk("rst_data", data_read_o, 64'd0);
    chk("rst_w_ready", 64'(w_ready_o), 64'd0);
    chk("rst_w_last", 64'(w_last_i), 64'd0);
    r_valid_i = 1'b0; w_valid_i = 1'b0;
    #2 rst = 1'b1;
    next_cycle();

    // 256-beat fill of words 0..255 exercises the full 8-bit beat count
    wq.delete();
    for (int i = 0; i < 256; i++) wq.push_back({$urandom(), $urandom()});
    do_write(32'h0, 255, 3);
    do_read(32'h0, 255);

    for (int k = 0; k < 12; k++) begin
      if (vecs[k].wr) begin
        wq.delete(); wq.push_back(vecs[k].data);
        do_write(vecs[k].addr, 0, vecs[k].size);
      end else begin
        do_read(vecs[k].addr, 0);
        chk($sformatf("vec%0d", k), rd_first, vecs[k].exp);
      end
    end

    wq = '{64'h11111111_11111111, 64'h22222222_22222222, 64'h33333333_33333333, 64'h44444444_44444444};
    do_write(32'h100, 3, 3);
    do_read(32'h100, 3);

    wq.delete();
    for (int i = 0; i < 4; i++) wq.push_back({$urandom(), $urandom()});
    do_write(32'((DEPTH - 2) * 8), 3, 3);
    do_read(32'((DEPTH - 2) * 8), 3);

    wq.delete();
    for (int i = 0; i < 8; i++) wq.push_back({$urandom(), $urandom()});
    do_write(32'h800, 7, 3);
    do_read(32'h800, 7, 3);
    do_read(32'h810, 1);

    wq.delete();
    for (int i = 0; i < 4; i++) wq.push_back({$urandom(), $urandom()});
    do_write(32'h900, 3, 3);
    wq.delete();
    for (int i = 0; i < 4; i++) wq.push_back({$urandom(), $urandom()});
    do_write(32'h900, 3, 3, 2);
    do_read(32'h900, 3);

    // Same-cycle read and write of word 5
    old_v = 64'h55555555_AAAAAAAA;
    new_v = 64'h0F0F0F0F_F0F0F0F0;
    wq = '{old_v};
    do_write(32'h28, 0, 3);
    r_valid_i = 1'b1; r_addr_i = 32'h28; r_len_i = 8'd0;
    next_cycle();
    next_cycle();
    w_valid_i = 1'b1; w_addr_i = 32'h28; w_len_i = 8'd0; w_size_i = 3'd3; rw_w_data_i = new_v;
    @(negedge clk); chk("cc_w_accept", 64'(w_ready_o), 64'd0);
    next_cycle();
    @(negedge clk);
    chk("cc_r_ready", 64'(r_ready_o), 64'd1);
    chk("cc_r_old", data_read_o, old_v);
    chk("cc_w_ready", 64'(w_ready_o), 64'd1);
    chk("cc_w_last", 64'(w_last_i), 64'd1);
    next_cycle();
    r_valid_i = 1'b0; w_valid_i = 1'b0;
    m_write(32'h28, 3, new_v);
    next_cycle();
    next_cycle();
    do_read(32'h28, 0);
    chk("cc_r_new", rd_first, new_v);

    // Reset asserted during the third beat of a 4-beat write
    wq.delete();
    for (int i = 0; i < 4; i++) wq.push_back({$urandom(), $urandom()});
    do_write(32'hA00, 3, 3);
    wq.delete();
    for (int i = 0; i < 4; i++) wq.push_back({$urandom(), $urandom()});
    w_valid_i = 1'b1; w_addr_i = 32'hA00; w_len_i = 8'd3; w_size_i = 3'd3;
    next_cycle();
    for (int i = 0; i < 2; i++) begin
      rw_w_data_i = wq[i];
      m_write(32'hA00 + 32'(8 * i), 3, wq[i]);
      next_cycle();
    end
    rw_w_data_i = wq[2];
    r_valid_i = 1'b1; r_addr_i = 32'hA00; r_len_i = 8'd0;
    #2 rst = 1'b0;
    #1;
    chk("mid_rst_w_ready", 64'(w_ready_o), 64'd0);
    chk("mid_rst_w_last", 64'(w_last_i), 64'd0);
    chk("mid_rst_r_ready", 64'(r_ready_o), 64'd0);
    chk("mid_rst_data", data_read_o, 64'd0);
    @(posedge clk);
    #1;
    w_valid_i = 1'b0; r_valid_i = 1'b0; rw_w_data_i = '0;
    #2 rst = 1'b1;
    next_cycle();
    do_read(32'hA00, 3);
    wq = '{64'hC0FFEE00_12345678};
    do_write(32'hA20, 0, 3);
    do_read(32'hA20, 0);

    for (int n = 0; n < 30; n++) begin
      int len;
      int size;
      len  = $urandom_range(0, 7);
      size = $urandom_range(0, 7);
      a = ($urandom() & 32'hFFFF_8000) | (32'($urandom_range(0, 200)) << 3) | 32'($urandom_range(0, 7));
      wq.delete();
      for (int i = 0; i <= len; i++) wq.push_back({$urandom(), $urandom()});
      do_write(a, len, size);
      len = $urandom_range(0, 7);
      a = ($urandom() & 32'hFFFF_8000) | (32'($urandom_range(0, 240)) << 3) | 32'($urandom_range(0, 7));
      do_read(a, len);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
